card_shoe_rng: RTL and testbench

//  Parametrised card source for the blackjack datapath. A W-bit maximal-length

---
 rtl/card_pkg.sv | 26 ++
 rtl/lfsr_core.sv | 41 ++++
 rtl/card_shoe_rng.sv | 140 ++++++++++++++
 tb/tb_card_shoe_rng.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared rank/suit constants, search FSM encoding and rank-to-points mapping
// for the blackjack card source.
package card_pkg;

    localparam int NUM_RANKS = 13;
    localparam int SUITS     = 4;
    localparam int RANK_W    = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_e;

    // Ace counts high here; soft-hand adjustment belongs to the hand scorer.
    function automatic logic [RANK_W-1:0] rank_to_points(input logic [RANK_W-1:0] rank);
        logic [RANK_W-1:0] pts;
        pts = rank;
        if (rank == 4'd1) begin
            pts = 4'd11;
        end else if (rank > 4'd10) begin
            pts = 4'd10;
        end
        return pts;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with seed load and an all-zero lock-up guard.
// A zero seed (parameter or port) is replaced by 1.
module lfsr_core #(
    parameter int               W    = 8,
    parameter logic [W-1:0]     TAPS = 8'hB8,
    parameter logic [W-1:0]     SEED = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] RESET_VAL = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = {q_q[W-2:0], ^(q_q & TAPS)};
        if (load) begin
            q_d = (load_val == '0) ? W'(1) : load_val;
        end else if (q_q == '0) begin
            q_d = W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_shoe_rng.sv
// Card source: rejection-samples the LFSR low nibble into ranks 1..13,
// drawing without replacement from a shoe of DECKS decks.
module card_shoe_rng
    import card_pkg::*;
#(
    parameter int                  LFSR_W = 8,
    parameter logic [LFSR_W-1:0]   TAPS   = 8'hB8,
    parameter logic [LFSR_W-1:0]   SEED   = 8'h01,
    parameter int                  DECKS  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            seed_load,
    input  logic [LFSR_W-1:0]               seed,
    input  logic                            shuffle,
    input  logic                            draw_req,
    output logic                            busy,
    output logic                            draw_valid,
    output logic [RANK_W-1:0]               card_rank,
    output logic [RANK_W-1:0]               card_points,
    output logic [$clog2(52*DECKS+1)-1:0]   cards_left,
    output logic                            shoe_empty
);

    localparam int CNT_W  = $clog2(SUITS*DECKS+1);
    localparam int LEFT_W = $clog2(52*DECKS+1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(SUITS*DECKS);
    localparam logic [LEFT_W-1:0] FULL_LEFT = LEFT_W'(52*DECKS);

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_hi_unused;
    logic [RANK_W-1:0] cand;
    logic              hit;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q [1:NUM_RANKS];
    logic [CNT_W-1:0]  count_d [1:NUM_RANKS];
    logic [LEFT_W-1:0] cards_left_q, cards_left_d;
    logic [RANK_W-1:0] card_rank_q, card_rank_d;
    logic [RANK_W-1:0] card_points_q, card_points_d;
    logic              draw_valid_q, draw_valid_d;

    lfsr_core #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed),
        .q        (lfsr)
    );

    // Only the low nibble forms the candidate; upper bits just widen the period.
    assign lfsr_hi_unused = ^(lfsr >> RANK_W);
    assign cand           = lfsr[RANK_W-1:0];

    // Candidates 0, 14 and 15 match no rank, so they are rejected here.
    always_comb begin
        hit = 1'b0;
        for (int r = 1; r <= NUM_RANKS; r++) begin
            if (cand == RANK_W'(r) && count_q[r] != '0) begin
                hit = 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        cards_left_d  = cards_left_q;
        card_rank_d   = card_rank_q;
        card_points_d = card_points_q;
        draw_valid_d  = 1'b0;

        if (shuffle) begin
            for (int r = 1; r <= NUM_RANKS; r++) begin
                count_d[r] = FULL_CNT;
            end
            cards_left_d = FULL_LEFT;
            state_d      = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (draw_req && cards_left_q != '0) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (hit) begin
                        for (int r = 1; r <= NUM_RANKS; r++) begin
                            if (cand == RANK_W'(r)) begin
                                count_d[r] = count_q[r] - CNT_W'(1);
                            end
                        end
                        cards_left_d  = cards_left_q - LEFT_W'(1);
                        card_rank_d   = cand;
                        card_points_d = rank_to_points(cand);
                        draw_valid_d  = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: the rank counters are architectural shoe state, so the whole
    // array is reset, unlike a data RAM whose contents may power up unknown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int r = 1; r <= NUM_RANKS; r++) begin
                count_q[r] <= FULL_CNT;
            end
            cards_left_q  <= FULL_LEFT;
            card_rank_q   <= '0;
            card_points_q <= '0;
            draw_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            cards_left_q  <= cards_left_d;
            card_rank_q   <= card_rank_d;
            card_points_q <= card_points_d;
            draw_valid_q  <= draw_valid_d;
        end
    end

    assign busy        = (state_q == ST_SEARCH);
    assign draw_valid  = draw_valid_q;
    assign card_rank   = card_rank_q;
    assign card_points = card_points_q;
    assign cards_left  = cards_left_q;
    assign shoe_empty  = (cards_left_q == '0);

endmodule

// File: tb/tb_card_shoe_rng.sv
// Directed bench for card_shoe_rng (LFSR_W=8, TAPS=8'hB8, SEED=8'h01, DECKS=1):
// seeded-draw vector table plus hand-written reset, shuffle and exhaust sequences.
module tb_card_shoe_rng;

    logic       clk;
    logic       rst;
    logic       seed_load;
    logic [7:0] seed;
    logic       shuffle;
    logic       draw_req;
    logic       busy;
    logic       draw_valid;
    logic [3:0] card_rank;
    logic [3:0] card_points;
    logic [5:0] cards_left;
    logic       shoe_empty;

    int n_checks = 0;
    int n_errors = 0;

    card_shoe_rng #(
        .LFSR_W (8),
        .TAPS   (8'hB8),
        .SEED   (8'h01),
        .DECKS  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_load   (seed_load),
        .seed        (seed),
        .shuffle     (shuffle),
        .draw_req    (draw_req),
        .busy        (busy),
        .draw_valid  (draw_valid),
        .card_rank   (card_rank),
        .card_points (card_points),
        .cards_left  (cards_left),
        .shoe_empty  (shoe_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seed;
        int         latency;
        logic [3:0] rank;
        logic [3:0] points;
        logic [5:0] left;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t       vecs [7];
    logic [7:0] lfsr_exp [7];
    int         seen [14];
    int         lat;
    int         n_draws;
    int         cyc;

    initial begin
        // Seeds chosen so the low nibble is (or quickly becomes) the wanted rank.
        // 0x0E: candidate 14 misses, next state 0x1D gives K on the second cycle.
        vecs[0] = '{seed: 8'h01, latency: 1, rank: 4'd1,  points: 4'd11, left: 6'd51};
        vecs[1] = '{seed: 8'h0A, latency: 1, rank: 4'd10, points: 4'd10, left: 6'd50};
        vecs[2] = '{seed: 8'h0C, latency: 1, rank: 4'd12, points: 4'd10, left: 6'd49};
        vecs[3] = '{seed: 8'h0E, latency: 2, rank: 4'd13, points: 4'd10, left: 6'd48};
        vecs[4] = '{seed: 8'h00, latency: 1, rank: 4'd1,  points: 4'd11, left: 6'd47};
        vecs[5] = '{seed: 8'h05, latency: 1, rank: 4'd5,  points: 4'd5,  left: 6'd46};
        vecs[6] = '{seed: 8'h0B, latency: 1, rank: 4'd11, points: 4'd10, left: 6'd45};

        lfsr_exp[0] = 8'h02; lfsr_exp[1] = 8'h04; lfsr_exp[2] = 8'h08;
        lfsr_exp[3] = 8'h11; lfsr_exp[4] = 8'h23; lfsr_exp[5] = 8'h47;
        lfsr_exp[6] = 8'h8E;

        rst = 1'b1; seed_load = 1'b0; seed = 8'h00; shuffle = 1'b0; draw_req = 1'b0;

        // Reset state, released between edges.
        #12 rst = 1'b0;
        #1;
        check("reset cards_left", 32'(cards_left), 32'd52);
        check("reset shoe_empty", 32'(shoe_empty), 32'd0);
        check("reset draw_valid", 32'(draw_valid), 32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset card_rank",  32'(card_rank),  32'd0);
        check("reset card_points",32'(card_points),32'd0);
        check("reset lfsr",       32'(dut.lfsr),   32'h01);

        // Seed 0 is replaced by 1, then the register follows the tap polynomial.
        tick();
        seed_load = 1'b1; seed = 8'h00;
        tick();
        seed_load = 1'b0;
        check("seed0 lfsr", 32'(dut.lfsr), 32'h01);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("lfsr step %0d", i + 1), 32'(dut.lfsr), 32'(lfsr_exp[i]));
        end

        // Seeded draws: load and request in the same cycle.
        for (int v = 0; v < 7; v++) begin
            seed_load = 1'b1; seed = vecs[v].seed; draw_req = 1'b1;
            tick();
            seed_load = 1'b0; draw_req = 1'b0;
            check($sformatf("vec%0d busy", v), 32'(busy), 32'd1);
            lat = 0;
            while (!draw_valid && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].latency));
            check($sformatf("vec%0d rank", v),    32'(card_rank),   32'(vecs[v].rank));
            check($sformatf("vec%0d points", v),  32'(card_points), 32'(vecs[v].points));
            check($sformatf("vec%0d left", v),    32'(cards_left),  32'(vecs[v].left));
            check($sformatf("vec%0d busy_done", v), 32'(busy), 32'd0);
            tick();
            check($sformatf("vec%0d pulse", v), 32'(draw_valid), 32'd0);
        end

        // Async reset mid-search (0x0E misses on its first search cycle).
        seed_load = 1'b1; seed = 8'h0E; draw_req = 1'b1;
        tick();
        seed_load = 1'b0; draw_req = 1'b0;
        check("arst busy before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst busy",        32'(busy),        32'd0);
        check("arst cards_left",  32'(cards_left),  32'd52);
        check("arst card_rank",   32'(card_rank),   32'd0);
        check("arst card_points", 32'(card_points), 32'd0);
        check("arst draw_valid",  32'(draw_valid),  32'd0);
        check("arst lfsr",        32'(dut.lfsr),    32'h01);
        #1 rst = 1'b0;
        tick();
        check("arst no late pulse", 32'(draw_valid), 32'd0);
        seed_load = 1'b1; seed = 8'h03; draw_req = 1'b1;
        tick();
        seed_load = 1'b0; draw_req = 1'b0;
        tick();
        check("post-rst valid",  32'(draw_valid),  32'd1);
        check("post-rst rank",   32'(card_rank),   32'd3);
        check("post-rst points", 32'(card_points), 32'd3);
        check("post-rst left",   32'(cards_left),  32'd51);

        // Shuffle while searching aborts the draw and refills the shoe.
        seed_load = 1'b1; seed = 8'h0E; draw_req = 1'b1;
        tick();
        seed_load = 1'b0; draw_req = 1'b0;
        check("shuf busy before", 32'(busy), 32'd1);
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        check("shuf busy",       32'(busy),       32'd0);
        check("shuf draw_valid", 32'(draw_valid), 32'd0);
        check("shuf cards_left", 32'(cards_left), 32'd52);
        check("shuf rank kept",  32'(card_rank),  32'd3);
        check("shuf points kept",32'(card_points),32'd3);
        tick();
        check("shuf no pulse", 32'(draw_valid), 32'd0);

        // Shuffle and draw_req together: request dropped.
        shuffle = 1'b1; draw_req = 1'b1;
        tick();
        shuffle = 1'b0; draw_req = 1'b0;
        check("shuf+req busy", 32'(busy), 32'd0);
        tick();
        check("shuf+req valid", 32'(draw_valid), 32'd0);
        check("shuf+req busy2", 32'(busy),       32'd0);

        // Exhaust the shoe with draw_req held high (back-to-back draws).
        for (int r = 0; r < 14; r++) seen[r] = 0;
        n_draws = 0;
        cyc     = 0;
        draw_req = 1'b1;
        while (n_draws < 52 && cyc < 20000) begin
            tick();
            cyc++;
            if (draw_valid) begin
                n_draws++;
                if (card_rank >= 4'd1 && card_rank <= 4'd13) seen[card_rank]++;
                else seen[0]++;
                check($sformatf("exh left %0d", n_draws), 32'(cards_left), 32'(52 - n_draws));
                check($sformatf("exh empty %0d", n_draws), 32'(shoe_empty), 32'(n_draws == 52));
            end
        end
        check("exh draws", 32'(n_draws), 32'd52);
        check("exh bad ranks", 32'(seen[0]), 32'd0);
        for (int r = 1; r <= 13; r++) begin
            check($sformatf("exh rank %0d count", r), 32'(seen[r]), 32'd4);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("empty busy %0d", i),  32'(busy),       32'd0);
            check($sformatf("empty valid %0d", i), 32'(draw_valid), 32'd0);
        end
        draw_req = 1'b0;
        check("empty left", 32'(cards_left), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
